// File: rtl/morse_tx.sv
// Morse transmitter: serialises 6-bit letter codes into one dit/dah symbol per clock,
// followed by GAP_CYCLES gap symbols per letter.
module morse_tx #(
  parameter int GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [0:5] letter,
  input  logic       letter_valid,
  output logic       letter_ready,
  output logic [0:1] ditDah,
  output logic       busy,
  output logic       bad_letter
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  localparam logic [3:0] GAP_INIT = 4'(GAP_CYCLES);

  state_t     state_q, state_d;
  logic [4:0] shreg_q, shreg_d;
  logic [2:0] cnt_q, cnt_d;
  logic [3:0] gap_q, gap_d;
  logic [1:0] sym_q, sym_d;
  logic       busy_q, busy_d;
  logic       bad_q, bad_d;

  logic       rom_ok;
  logic [2:0] rom_len;
  logic [4:0] rom_pat;
  logic       accept;

  // Patterns are left-aligned: bit 4 is the first symbol, 1 = dah.
  always_comb begin
    rom_ok  = 1'b1;
    rom_len = 3'd0;
    rom_pat = 5'b00000;
    case (letter)
      6'd1:  begin rom_len = 3'd2; rom_pat = 5'b01000; end
      6'd2:  begin rom_len = 3'd4; rom_pat = 5'b10000; end
      6'd3:  begin rom_len = 3'd4; rom_pat = 5'b10100; end
      6'd4:  begin rom_len = 3'd3; rom_pat = 5'b10000; end
      6'd5:  begin rom_len = 3'd1; rom_pat = 5'b00000; end
      6'd6:  begin rom_len = 3'd4; rom_pat = 5'b00100; end
      6'd7:  begin rom_len = 3'd3; rom_pat = 5'b11000; end
      6'd8:  begin rom_len = 3'd4; rom_pat = 5'b00000; end
      6'd9:  begin rom_len = 3'd2; rom_pat = 5'b00000; end
      6'd10: begin rom_len = 3'd4; rom_pat = 5'b01110; end
      6'd11: begin rom_len = 3'd3; rom_pat = 5'b10100; end
      6'd12: begin rom_len = 3'd4; rom_pat = 5'b01000; end
      6'd13: begin rom_len = 3'd2; rom_pat = 5'b11000; end
      6'd14: begin rom_len = 3'd2; rom_pat = 5'b10000; end
      6'd15: begin rom_len = 3'd3; rom_pat = 5'b11100; end
      6'd16: begin rom_len = 3'd4; rom_pat = 5'b01100; end
      6'd17: begin rom_len = 3'd4; rom_pat = 5'b11010; end
      6'd18: begin rom_len = 3'd3; rom_pat = 5'b01000; end
      6'd19: begin rom_len = 3'd3; rom_pat = 5'b00000; end
      6'd20: begin rom_len = 3'd1; rom_pat = 5'b10000; end
      6'd21: begin rom_len = 3'd3; rom_pat = 5'b00100; end
      6'd22: begin rom_len = 3'd4; rom_pat = 5'b00010; end
      6'd23: begin rom_len = 3'd3; rom_pat = 5'b01100; end
      6'd24: begin rom_len = 3'd4; rom_pat = 5'b10010; end
      6'd25: begin rom_len = 3'd4; rom_pat = 5'b10110; end
      6'd26: begin rom_len = 3'd4; rom_pat = 5'b11000; end
      6'd27: begin rom_len = 3'd5; rom_pat = 5'b11111; end
      6'd28: begin rom_len = 3'd5; rom_pat = 5'b01111; end
      6'd29: begin rom_len = 3'd5; rom_pat = 5'b00111; end
      6'd30: begin rom_len = 3'd5; rom_pat = 5'b00011; end
      6'd31: begin rom_len = 3'd5; rom_pat = 5'b00001; end
      6'd32: begin rom_len = 3'd5; rom_pat = 5'b00000; end
      6'd33: begin rom_len = 3'd5; rom_pat = 5'b10000; end
      6'd34: begin rom_len = 3'd5; rom_pat = 5'b11000; end
      6'd35: begin rom_len = 3'd5; rom_pat = 5'b11100; end
      6'd36: begin rom_len = 3'd5; rom_pat = 5'b11110; end
      6'd37: begin rom_len = 3'd4; rom_pat = 5'b00110; end
      6'd38: begin rom_len = 3'd4; rom_pat = 5'b11110; end
      6'd39: begin rom_len = 3'd4; rom_pat = 5'b11100; end
      default: rom_ok = 1'b0;
    endcase
  end

  assign letter_ready = (state_q == IDLE) || ((state_q == GAP) && (gap_q == 4'd1));
  assign accept       = letter_valid & letter_ready;

  // cnt_q holds the symbols still to send after the one currently on ditDah;
  // gap_q counts the gap cycles left including the current one.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    sym_d   = 2'b01;
    busy_d  = 1'b0;
    bad_d   = 1'b0;
    case (state_q)
      SEND: begin
        busy_d = 1'b1;
        if (cnt_q != 3'd0) begin
          sym_d   = {2{shreg_q[4]}};
          shreg_d = {shreg_q[3:0], 1'b0};
          cnt_d   = cnt_q - 3'd1;
        end else begin
          state_d = GAP;
          gap_d   = GAP_INIT;
        end
      end
      GAP: begin
        if (gap_q != 4'd1) begin
          gap_d  = gap_q - 4'd1;
          busy_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      if (rom_ok) begin
        state_d = SEND;
        sym_d   = {2{rom_pat[4]}};
        shreg_d = {rom_pat[3:0], 1'b0};
        cnt_d   = rom_len - 3'd1;
        busy_d  = 1'b1;
      end else begin
        state_d = IDLE;
        bad_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= 5'b00000;
      cnt_q   <= 3'd0;
      gap_q   <= 4'd0;
      sym_q   <= 2'b01;
      busy_q  <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      sym_q   <= sym_d;
      busy_q  <= busy_d;
      bad_q   <= bad_d;
    end
  end

  assign ditDah     = sym_q;
  assign busy       = busy_q;
  assign bad_letter = bad_q;

endmodule

// File: tb/tb_morse_tx.sv
// Scoreboard bench for morse_tx: a string-based Morse table expands each accepted
// letter into an expected symbol stream that a negedge monitor checks cycle by cycle.
module tb_morse_tx;

  localparam int GAP = 3;

  logic       clk;
  logic       rst_n;
  logic [0:5] letter;
  logic       letter_valid;
  logic       letter_ready;
  logic [0:1] ditDah;
  logic       busy;
  logic       bad_letter;

  morse_tx #(.GAP_CYCLES(GAP)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .letter       (letter),
    .letter_valid (letter_valid),
    .letter_ready (letter_ready),
    .ditDah       (ditDah),
    .busy         (busy),
    .bad_letter   (bad_letter)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0] exp_q[$];
  bit         bad_pending = 1'b0;

  string mtab[40] = '{"",
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
    "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
    "..-", "...-", ".--", "-..-", "-.--", "--..",
    "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...", "---..", "----.",
    "..--", "----", "---."};

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: expand an accepted code into its symbol stream.
  task automatic model_accept(input int code);
    string s;
    if (code >= 1 && code <= 39) begin
      s = mtab[code];
      for (int i = 0; i < s.len(); i++)
        exp_q.push_back(s[i] == "-" ? 2'b11 : 2'b00);
      for (int i = 0; i < GAP; i++)
        exp_q.push_back(2'b01);
      $display("accept code %0d \"%s\" at %0t", code, s, $time);
    end else begin
      bad_pending = 1'b1;
      $display("accept invalid code %0d at %0t", code, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [1:0] e_sym;
    logic       e_busy;
    logic       e_ready;
    if (exp_q.size() > 0) begin
      e_sym  = exp_q.pop_front();
      e_busy = 1'b1;
    end else begin
      e_sym  = 2'b01;
      e_busy = 1'b0;
    end
    e_ready = (exp_q.size() == 0);
    chk("ditDah", 8'(ditDah), 8'(e_sym));
    chk("busy", 8'(busy), 8'(e_busy));
    chk("letter_ready", 8'(letter_ready), 8'(e_ready));
    chk("bad_letter", 8'(bad_letter), 8'(bad_pending));
    bad_pending = 1'b0;
  end

  task automatic send(input int code);
    int n;
    n = 0;
    @(negedge clk);
    #1;
    letter       = 6'(code);
    letter_valid = 1'b1;
    while (!letter_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!letter_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL handshake_timeout: code %0d never accepted, ready %0b required 1", code, letter_ready);
    end else begin
      @(posedge clk);
      model_accept(code);
    end
  endtask

  task automatic idle(input int n);
    if (n > 0) begin
      @(negedge clk);
      #1;
      letter_valid = 1'b0;
      repeat (n) @(posedge clk);
    end
  endtask

  initial begin
    rst_n        = 1'b1;
    letter       = 6'd0;
    letter_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ditDah", 8'(ditDah), 8'h01);
    chk("rst_busy", 8'(busy), 8'h00);
    chk("rst_bad", 8'(bad_letter), 8'h00);
    chk("rst_ready", 8'(letter_ready), 8'h01);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    idle(10);

    // Directed: A, digit 0, invalid pair then E.
    send(1);
    idle(8);
    send(27);
    idle(10);
    send(0);
    send(45);
    send(5);
    idle(8);

    // Sweep every legal code back-to-back with valid held high.
    for (int c = 1; c <= 39; c++) send(c);
    idle(10);

    // Random codes (including invalid ones) with random idle spacing.
    for (int k = 0; k < 150; k++) begin
      send(int'($urandom_range(0, 63)));
      idle(int'($urandom_range(0, 3)));
    end
    idle(10);

    // Asynchronous reset partway through '5' after two dits.
    send(32);
    @(negedge clk);
    #1 letter_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    exp_q.delete();
    bad_pending = 1'b0;
    #1;
    chk("abort_ditDah", 8'(ditDah), 8'h01);
    chk("abort_busy", 8'(busy), 8'h00);
    chk("abort_ready", 8'(letter_ready), 8'h01);
    @(negedge clk);
    #1 rst_n = 1'b1;
    idle(3);
    send(20);
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/morse_tx.md
# morse_tx

Morse transmitter: accepts 6-bit letter codes on a valid/ready handshake and serialises each into one dit/dah symbol per clock on `ditDah`, followed by inter-letter gap symbols. It is the sending end of the `morse_rx` link and drives `morse_rx.ditDah` directly through the channel model. Letter codes and symbol encodings match `morse_rx` exactly, so a loopback returns the original code.

## Interface
- `GAP_CYCLES`, default 1: gap symbols emitted after each letter. Legal range 1..15.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `letter`  in  [0:5]  letter code. 1..26 = A..Z, 27..36 = digits 0..9, 37 = SPACE, 38 = '-', 39 = '.'.
- `letter_valid`  in  1  `letter` is valid this cycle.
- `letter_ready`  out  1  block accepts `letter` this cycle.
- `ditDah`  out  [0:1]  symbol, one per clock. 2'b00 = dit, 2'b11 = dah, 2'b01 = gap/idle.
- `busy`  out  1  a letter is being sent, including its gap symbols.
- `bad_letter`  out  1  one-cycle pulse: an unsupported code was accepted and dropped.

## Operation
- Code ROM (combinational) gives a length L (1..5) and a 5-bit pattern sent MSB-first, where 1 = dah and 0 = dit.
- ROM contents:
  - A .-, B -..., C -.-., D -.., E ., F ..-., G --., H ...., I .., J .---, K -.-, L .-.., M --
  - N -., O ---, P .--., Q --.-, R .-., S ..., T -, U ..-, V ...-, W .--, X -..-, Y -.--, Z --..
  - 0 -----, 1 .----, 2 ..---, 3 ...--, 4 ....-, 5 ....., 6 -...., 7 --..., 8 ---.., 9 ----.
  - SPACE ..--, '-' ----, '.' ---.
- Codes 0 and 40..63 are invalid.
- FSM states: IDLE, SEND, GAP.
  - IDLE: `ditDah` = 01, `busy` = 0, `letter_ready` = 1.
    - Valid code accepted: load the pattern shift register and the symbol counter (L), go to SEND.
    - Invalid code accepted: pulse `bad_letter` next cycle, stay in IDLE.
  - SEND: each cycle drive the pattern MSB (dah → 11, dit → 00), shift, and decrement the counter. After the L-th symbol, go to GAP with the gap counter = GAP_CYCLES.
  - GAP: drive 01 and decrement the gap counter. `letter_ready` = 1 only in the final gap cycle.
    - Accept in the final gap cycle: go straight to SEND with the new letter (invalid code: go to IDLE and pulse `bad_letter`).
    - Final gap cycle with no accept: go to IDLE.
- `ditDah`, `busy`, and `bad_letter` are registered.
- `letter_ready` is combinational from state and counters. It never depends on `letter_valid`.
- Input is sampled only on the handshake. Holding `letter_valid` high with the same code sends that code repeatedly.
- Reset mid-letter aborts immediately: `ditDah` = 01, FSM to IDLE. A downstream receiver will then decode the partial prefix as a letter. This is accepted behaviour.

## Timing
- Reset values: `ditDah` = 2'b01, `busy` = 0, `bad_letter` = 0, state IDLE, `letter_ready` = 1 (also asserted during reset).
- Accept at edge t (valid & ready):
  - symbols appear at t+1 .. t+L;
  - gap symbols appear at t+L+1 .. t+L+GAP_CYCLES;
  - `busy` is high over t+1 .. t+L+GAP_CYCLES.
- Back-to-back letters: the next accept occurs in cycle t+L+GAP_CYCLES and its first symbol appears at t+L+GAP_CYCLES+1. Exactly GAP_CYCLES gap symbols separate the letters.
- Throughput: one letter per L+GAP_CYCLES cycles.
- `morse_rx` outputs the letter on the edge that samples the first gap symbol, so it is valid one cycle after cycle t+L+1.
- Invalid code accepted at t: `bad_letter` = 1 in cycle t+1 only, `ditDah` stays 01, `busy` stays 0, and `letter_ready` stays 1.

## Test plan
- Reset, then send 'A' (1) with GAP_CYCLES = 1 → `ditDah` 00, 11, 01 at t+1..t+3. `busy` high for 3 cycles. Loopback `morse_rx.letter` = 1.
- Sweep all codes 1..39 back-to-back, `letter_valid` held high → each letter's symbols match the ROM, exactly one 01 between letters, and the loopback receiver reproduces every code in order.
- GAP_CYCLES = 3, send '0' (27) → five 11 symbols, then three 01 symbols. `letter_ready` low for 7 cycles after accept, high in the 8th.
- Send codes 0, then 45, then E (5) → `bad_letter` pulses at t+1 and t+2, `ditDah` stays 01, then E emits a single 00 followed by 01.
- Assert `rst_n` = 0 mid-way through '5' (32), after 2 dits → `ditDah` = 01 immediately (asynchronously), `busy` = 0, `letter_ready` = 1. After release, sending T (20) emits 11, 01.
- `letter_valid` low for 10 cycles after reset → `ditDah` constant 01, `busy` = 0, no `bad_letter` pulse.
